// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and bit timing.
// Used by both the transmit and receive sequencers.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int TICKS_PER_BIT = 16;
  localparam int TICK_CNT_W    = $clog2(TICKS_PER_BIT);

endpackage : uart_pkg

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte on valid/ready and shifts out
// start, data (LSB first), optional parity and stop bits on the 16x tick.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iTick16x,
  input  logic [DATA_BITS-1:0] iData,
  input  logic                 iValid,
  output logic                 oReady,
  output logic                 oTx,
  output logic                 oBusy,
  output logic                 oDone
);

  if (DATA_BITS < 5 || DATA_BITS > 8 ||
      (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
    $error("uart_tx_ctrl: illegal DATA_BITS/PARITY/STOP_BITS");
  end

  localparam logic [TICK_CNT_W-1:0] TICK_LAST = TICK_CNT_W'(TICKS_PER_BIT - 1);
  localparam logic [2:0]            DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]            STOP_LAST = 3'(STOP_BITS - 1);

  uart_state_e            state_q, state_d;
  logic [TICK_CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   bit_end;

  // The tick only counts while a frame is in progress; IDLE holds the counter at 0.
  assign bit_end = iTick16x && (tick_cnt_q == TICK_LAST) && (state_q != S_IDLE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    done_d     = 1'b0;
    tx_d       = 1'b1;

    if (state_q != S_IDLE && iTick16x) begin
      tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (iValid) begin
          shift_d    = iData;
          par_d      = (PARITY == PAR_ODD) ? ~^iData : ^iData;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the registered state, so oTx lags the state by one cycle.
    unique case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
      S_PARITY: tx_d = par_q;
      default:  tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign oReady = (state_q == S_IDLE);
  assign oBusy  = (state_q != S_IDLE);
  assign oTx    = tx_q;
  assign oDone  = done_q;

endmodule : uart_tx_ctrl

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: four configurations share clock, reset
// and a tick every 4 cycles; frames are modelled at handshake and checked on the line.
module tb_uart_tx_ctrl;

  localparam int BIT_CYC = 64;

  typedef struct {
    int          inst;
    logic [15:0] bits;
    int          nbits;
  } frame_t;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iTick16x = 1'b0;
  logic [1:0] tdiv = 2'd0;
  logic [7:0] data  [4];
  logic       valid [4];
  logic       ready [4];
  logic       tx    [4];
  logic       busy  [4];
  logic       done  [4];
  int         done_cnt [4] = '{0, 0, 0, 0};
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  frame_t     exp_q[$];

  always #5 iClk = ~iClk;

  always @(posedge iClk) begin
    tdiv     <= tdiv + 2'd1;
    iTick16x <= (tdiv == 2'd2);
    cyc      <= cyc + 1;
    for (int i = 0; i < 4; i++) if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
  end

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 5N2
  uart_tx_ctrl #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_d8n1 (
    .iClk(iClk), .iRst(iRst), .iTick16x(iTick16x), .iData(data[0]), .iValid(valid[0]),
    .oReady(ready[0]), .oTx(tx[0]), .oBusy(busy[0]), .oDone(done[0]));
  uart_tx_ctrl #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_d8e1 (
    .iClk(iClk), .iRst(iRst), .iTick16x(iTick16x), .iData(data[1]), .iValid(valid[1]),
    .oReady(ready[1]), .oTx(tx[1]), .oBusy(busy[1]), .oDone(done[1]));
  uart_tx_ctrl #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_d8o1 (
    .iClk(iClk), .iRst(iRst), .iTick16x(iTick16x), .iData(data[2]), .iValid(valid[2]),
    .oReady(ready[2]), .oTx(tx[2]), .oBusy(busy[2]), .oDone(done[2]));
  uart_tx_ctrl #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_d5n2 (
    .iClk(iClk), .iRst(iRst), .iTick16x(iTick16x), .iData(data[3][4:0]), .iValid(valid[3]),
    .oReady(ready[3]), .oTx(tx[3]), .oBusy(busy[3]), .oDone(done[3]));

  function automatic frame_t model(input int inst, input logic [7:0] d);
    frame_t f;
    int     db, par, sb, n;
    logic   p_even;
    db  = (inst == 3) ? 5 : 8;
    par = (inst == 1) ? 2 : (inst == 2) ? 1 : 0;
    sb  = (inst == 3) ? 2 : 1;
    f.inst = inst;
    f.bits = '1;
    n = 0;
    f.bits[n] = 1'b0; n++;
    p_even = 1'b0;
    for (int k = 0; k < db; k++) begin
      f.bits[n] = d[k]; n++;
      p_even ^= d[k];
    end
    if (par == 1) begin f.bits[n] = ~p_even; n++; end
    if (par == 2) begin f.bits[n] = p_even;  n++; end
    for (int k = 0; k < sb; k++) begin f.bits[n] = 1'b1; n++; end
    f.nbits = n;
    return f;
  endfunction

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input int inst, input logic [7:0] d, input bit hold);
    int k;
    data[inst]  = d;
    valid[inst] = 1'b1;
    k = 0;
    while (ready[inst] !== 1'b1 && k < 2000) begin @(negedge iClk); k++; end
    n_checks++;
    if (ready[inst] !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready_timeout inst=%0d ready=%b required=1", inst, ready[inst]);
      valid[inst] = 1'b0;
      return;
    end
    @(posedge iClk);
    exp_q.push_back(model(inst, d));
    @(negedge iClk);
    if (!hold) valid[inst] = 1'b0;
    n_checks++;
    if (tx[inst] !== 1'b1 || busy[inst] !== 1'b1 || ready[inst] !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_state inst=%0d tx/busy/ready=%b%b%b required=110",
               inst, tx[inst], busy[inst], ready[inst]);
    end
  endtask

  // Pops one expected frame, samples each bit mid-period and checks oDone timing.
  task automatic check_frame(input string name);
    frame_t f;
    int     k, fall, off, d0, lo, hi;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_scoreboard_empty size=0 required>0", name);
      return;
    end
    f  = exp_q.pop_front();
    d0 = done_cnt[f.inst];
    k  = 0;
    while (tx[f.inst] !== 1'b0 && k < 200) begin @(negedge iClk); k++; end
    n_checks++;
    if (tx[f.inst] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_no_start tx=%b required=0", name, tx[f.inst]);
      return;
    end
    fall = cyc;
    for (int i = 0; i < f.nbits; i++) begin
      repeat (fall + i * BIT_CYC + 32 - cyc) @(negedge iClk);
      n_checks++;
      if (tx[f.inst] !== f.bits[i]) begin
        n_fail++;
        $display("FAIL %s_bit%0d tx=%b required=%b", name, i, tx[f.inst], f.bits[i]);
      end
    end
    k = 0;
    while (done[f.inst] !== 1'b1 && k < BIT_CYC) begin @(negedge iClk); k++; end
    n_checks++;
    if (done[f.inst] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done_timeout done=%b required=1", name, done[f.inst]);
      return;
    end
    off = cyc - fall;
    lo  = 60 + (f.nbits - 1) * BIT_CYC;
    hi  = 63 + (f.nbits - 1) * BIT_CYC;
    n_checks++;
    if (off < lo || off > hi) begin
      n_fail++;
      $display("FAIL %s_done_time offset=%0d required=%0d..%0d", name, off, lo, hi);
    end
    n_checks++;
    if (tx[f.inst] !== 1'b1 || ready[f.inst] !== 1'b1 || busy[f.inst] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_state tx/ready/busy=%b%b%b required=110",
               name, tx[f.inst], ready[f.inst], busy[f.inst]);
    end
    @(negedge iClk);
    n_checks++;
    if (done[f.inst] !== 1'b0 || done_cnt[f.inst] - d0 != 1) begin
      n_fail++;
      $display("FAIL %s_done_pulse done=%b pulses=%0d required done=0 pulses=1",
               name, done[f.inst], done_cnt[f.inst] - d0);
    end
  endtask

  task automatic test_reset();
    int d0;
    iRst = 1'b1;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tx[i] !== 1'b1 || ready[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_values inst=%0d tx/ready/busy/done=%b%b%b%b required=1100",
                 i, tx[i], ready[i], busy[i], done[i]);
      end
    end
    iRst = 1'b0;
    @(negedge iClk);
    send(0, 8'hA5, 1'b0);
    void'(exp_q.pop_back());
    d0 = done_cnt[0];
    repeat (2 * BIT_CYC + 32) @(negedge iClk);
    n_checks++;
    if (busy[0] !== 1'b1 || tx[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pre_frame busy/tx=%b%b required=10", busy[0], tx[0]);
    end
    iRst = 1'b1;
    @(negedge iClk);
    n_checks++;
    if (tx[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_frame tx/ready/busy/done=%b%b%b%b required=1100",
               tx[0], ready[0], busy[0], done[0]);
    end
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
    n_checks++;
    if (tx[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0 || done_cnt[0] != d0) begin
      n_fail++;
      $display("FAIL reset_release tx/ready/busy=%b%b%b pulses=%0d required=110 pulses=0",
               tx[0], ready[0], busy[0], done_cnt[0] - d0);
    end
  endtask

  task automatic test_basic_frame();
    send(0, 8'h35, 1'b0);
    check_frame("basic");
  endtask

  task automatic test_parity();
    send(1, 8'h07, 1'b0);
    check_frame("par_even_07");
    send(2, 8'h07, 1'b0);
    check_frame("par_odd_07");
    send(1, 8'h00, 1'b0);
    check_frame("par_even_00");
  endtask

  task automatic test_back_to_back();
    send(0, 8'h55, 1'b1);
    data[0] = 8'hAA;
    check_frame("b2b_first");
    exp_q.push_back(model(0, 8'hAA));
    valid[0] = 1'b0;
    n_checks++;
    if (busy[0] !== 1'b1 || tx[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept busy/tx=%b%b required=11", busy[0], tx[0]);
    end
    @(negedge iClk);
    n_checks++;
    if (tx[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_start_fall tx=%b required=0", tx[0]);
    end
    check_frame("b2b_second");
  endtask

  task automatic test_busy_holdoff();
    int bad;
    bad = 0;
    send(0, 8'h12, 1'b0);
    fork
      check_frame("holdoff");
      begin
        int k;
        repeat (200) @(negedge iClk);
        data[0]  = 8'hFF;
        valid[0] = 1'b1;
        k = 0;
        while (done[0] !== 1'b1 && k < 1500) begin
          if (ready[0] !== 1'b0) bad++;
          @(negedge iClk);
          k++;
        end
        valid[0] = 1'b0;
      end
    join
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL holdoff_ready ready_high_cycles=%0d required=0", bad);
    end
  endtask

  task automatic test_two_stop();
    send(3, 8'h1F, 1'b0);
    check_frame("d5s2");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      valid[i] = 1'b0;
      data[i]  = 8'h00;
    end
    iRst = 1'b1;
    @(negedge iClk);
    test_reset();
    test_basic_frame();
    test_parity();
    test_back_to_back();
    test_busy_holdoff();
    test_two_stop();
    repeat (4) @(negedge iClk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time_limit_reached checks=%0d", n_checks);
    $fatal(1, "simulation time limit");
  end

endmodule : tb_uart_tx_ctrl

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit sequencer that turns a byte handed over on a valid/ready handshake into a serial frame on `oTx`. A frame is start bit, data bits LSB first, optional parity, then stop bits. Bit timing comes only from the shared 16x oversampling tick produced by `baud_rate_gen`, which is instantiated at the UART top level and feeds any number of TX/RX blocks. This block is the consumer and scheduler of that tick and has no clock-frequency knowledge of its own.

## Interface
- `DATA_BITS`, 8, data bits per frame; legal 5..8.
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, stop bits per frame; legal 1 or 2.
- `iClk`  in  1  system clock; the single clock domain.
- `iRst`  in  1  reset; synchronous, active-high.
- `iTick16x`  in  1  one-cycle pulse at 16x baud, from `baud_rate_gen`.
- `iData`  in  DATA_BITS  byte to send; sampled only on handshake.
- `iValid`  in  1  requester has a byte.
- `oReady`  out  1  block accepts a byte this cycle.
- `oTx`  out  1  serial line; idle high.
- `oBusy`  out  1  frame in progress.
- `oDone`  out  1  one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Handshake:
  - `oReady` = 1 exactly when state is IDLE; it is combinational from the state register.
  - A transfer occurs on a rising edge where `iValid` and `oReady` are both 1.
  - On that edge: latch `iData` into the shift register, compute the parity bit from the latched data, clear the tick counter and bit counter, and enter START.
  - `iValid` while busy is ignored. No data is dropped, because `oReady` is low.
- Tick counter: 4 bits, 0..15. It advances only on cycles where `iTick16x` = 1. When it is 15 and a tick arrives, it wraps to 0 and the current bit ends.
- State transitions, each taken on a bit end:
  - START goes to DATA.
  - DATA shifts right one position and increments the bit counter. After bit DATA_BITS-1 it goes to PARITY when PARITY != 0, otherwise to STOP.
  - PARITY goes to STOP.
  - STOP counts STOP_BITS bits, then goes to IDLE.
- Parity: odd parity is the XNOR-reduce of the data bits; even parity is the XOR-reduce.
- Line level per state: IDLE 1, START 0, DATA = shift register bit 0, PARITY = parity bit, STOP 1.
- `oTx` is driven from a register, so the line never glitches.
- `oBusy` = 1 in every state except IDLE.
- `oDone` pulses 1 on the edge that moves STOP to IDLE. In that same cycle `oReady` = 1, so a back-to-back transfer is legal and produces no idle gap beyond that single cycle.
- Parameter values outside the legal ranges fail elaboration; use a generate-time check.

## Timing
- Reset values: `oTx` = 1, `oReady` = 1, `oBusy` = 0, `oDone` = 0, state IDLE, all counters 0.
- Reset has priority over all other activity. Asserting it mid-frame returns to IDLE and drives `oTx` high on the next edge; the frame is abandoned and no `oDone` is produced.
- `oTx` falls for the start bit on the edge after the handshake edge, which is 1 cycle of latency.
- Start bit duration: 16 ticks, plus the partial tick period between acceptance and the first tick, which is 0..CNT_MAX-1 cycles.
- Every subsequent bit lasts exactly 16 tick periods.
- The frame is 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bits long.
- A tick arriving on the handshake edge is not counted. Counting starts on the cycle after the handshake.
- The tick is never consumed in IDLE; the counter holds at 0 there.

## Structure
- A shared package `uart_pkg` holds:
  - the state encoding localparams: IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4;
  - the parity mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - the tick wrap value TICKS_PER_BIT = 16.
- `uart_rx_ctrl` reuses the package later.
- No sub-module. `baud_rate_gen` stays external so one generator serves both TX and RX.

## Test plan
- **Reset.** Assert `iRst` for 3 cycles mid-DATA of a frame carrying 0xA5. Required next cycle: `oTx` = 1, `oReady` = 1, `oBusy` = 0, no `oDone`.
- **Basic frame.** Tick every 4 cycles; DATA_BITS = 8, PARITY = 0, STOP_BITS = 1; send 0x35. Required `oTx` sequence, 64 cycles per bit after start: 0, 1,0,1,0,1,1,0,0, 1. `oDone` pulses once after 10 bits.
- **Parity.** PARITY = 2 with 0x07 gives parity bit 1. PARITY = 1 with 0x07 gives parity bit 0. PARITY = 2 with 0x00 gives parity bit 0.
- **Back-to-back.** Hold `iValid` = 1 with 0x55 then 0xAA. The second handshake lands in the `oDone` cycle, and the second start bit falls 1 cycle after that.
- **Busy hold-off.** Change `iData` to 0xFF with `iValid` = 1 mid-frame. The transmitted byte stays the originally latched 0x12, and `oReady` stays 0 until `oDone`.
- **Two stop bits, 5-bit data.** DATA_BITS = 5, STOP_BITS = 2; send 0x1F. The frame is 8 bits long and the line stays high for 128 cycles, covering the two stop bits, before `oDone`.
